// File: rtl/par_serial_tx_if.sv
// par_serial_tx_if -- bundle of the word-in / bit-out signals of par_serial_tx.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The word channel (din/din_valid/din_ready) is offered by the producer.
//   The bit channel (sout/sout_valid/sout_ready) is offered by the framer.
//   While valid is high and ready is low the offering side holds its payload
//   stable. The framer's din_ready never depends combinationally on din_valid.
//
// Modports:
//   master - producer/consumer side: drives din, din_valid, sout_ready
//   slave  - framer side: drives din_ready, sout, sout_valid, sout_is_par,
//            frame_done, busy and the debug state
interface par_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_is_par;
  logic             frame_done;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output din, din_valid, sout_ready,
    input  din_ready, sout, sout_valid, sout_is_par, frame_done, busy, dbg_state
  );

  modport slave (
    input  din, din_valid, sout_ready,
    output din_ready, sout, sout_valid, sout_is_par, frame_done, busy, dbg_state
  );
endinterface

// File: rtl/par_serial_tx.sv
// par_serial_tx -- parallel-in, serial-out parity framer.
//
// Accepts a WIDTH-bit word when idle, shifts it out LSB first (one bit per
// cycle in which the consumer asserts sout_ready) and then appends one parity
// bit. ODD = 1 gives odd parity (all-zero word -> parity 1), ODD = 0 even.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset; aborts any frame in flight
//   bus    - par_serial_tx_if.slave:
//              din, din_valid, din_ready        word input handshake
//              sout, sout_valid, sout_ready     serial bit output handshake
//              sout_is_par                      current bit is the parity bit
//              frame_done                       parity bit consumed this cycle
//              busy                             frame in progress
//              dbg_state                        FSM state (IDLE=0 DATA=1 PARITY=2)
module par_serial_tx #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  par_serial_tx_if.slave  bus
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             acc;
  logic             sout_r;
  logic             sout_valid_r;
  logic             sout_is_par_r;
  logic             busy_r;
  logic             din_ready_r;

  // All outputs except frame_done are flops updated alongside the state, so
  // the serial bit is already presented in the cycle after it is decided.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      count         <= '0;
      acc           <= 1'b0;
      sout_r        <= 1'b0;
      sout_valid_r  <= 1'b0;
      sout_is_par_r <= 1'b0;
      busy_r        <= 1'b0;
      din_ready_r   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.din_valid) begin
            shreg        <= bus.din;
            count        <= '0;
            acc          <= ODD;
            state        <= DATA;
            sout_r       <= bus.din[0];
            sout_valid_r <= 1'b1;
            busy_r       <= 1'b1;
            din_ready_r  <= 1'b0;
          end
        end
        DATA: begin
          if (bus.sout_ready) begin
            acc   <= acc ^ shreg[0];
            shreg <= shreg >> 1;
            if (count == LAST) begin
              // Last data bit consumed: the next bit shown is the finished
              // parity, which already includes the bit leaving now.
              state         <= PARITY;
              sout_r        <= acc ^ shreg[0];
              sout_is_par_r <= 1'b1;
            end else begin
              // Count stops at WIDTH-1 so it never wraps for power-of-two widths.
              count  <= count + 1'b1;
              sout_r <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (bus.sout_ready) begin
            state         <= IDLE;
            sout_r        <= 1'b0;
            sout_valid_r  <= 1'b0;
            sout_is_par_r <= 1'b0;
            busy_r        <= 1'b0;
            din_ready_r   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sout        = sout_r;
  assign bus.sout_valid  = sout_valid_r;
  assign bus.sout_is_par = sout_is_par_r;
  assign bus.busy        = busy_r;
  assign bus.din_ready   = din_ready_r;
  assign bus.dbg_state   = state;
  // Pulses exactly on the edge that consumes the parity bit.
  assign bus.frame_done  = sout_valid_r & sout_is_par_r & bus.sout_ready;

endmodule

// File: tb/tb_par_serial_tx.sv
`timescale 1ns/1ps
module tb_par_serial_tx;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic [7:0] din8 = '0;
  logic       dv8  = 1'b0;
  logic       rdy8 = 1'b1;
  logic [2:0] din3 = '0;
  logic       dv3  = 1'b0;
  logic       rdy3 = 1'b1;

  par_serial_tx_if #(.WIDTH(8)) if8o ();
  par_serial_tx_if #(.WIDTH(8)) if8e ();
  par_serial_tx_if #(.WIDTH(3)) if3 ();

  assign if8o.din = din8;  assign if8o.din_valid = dv8;  assign if8o.sout_ready = rdy8;
  assign if8e.din = din8;  assign if8e.din_valid = dv8;  assign if8e.sout_ready = rdy8;
  assign if3.din  = din3;  assign if3.din_valid  = dv3;  assign if3.sout_ready  = rdy3;

  par_serial_tx #(.WIDTH(8), .ODD(1'b1)) u_dut_o8 (.clk(clk), .reset(reset), .bus(if8o.slave));
  par_serial_tx #(.WIDTH(8), .ODD(1'b0)) u_dut_e8 (.clk(clk), .reset(reset), .bus(if8e.slave));
  par_serial_tx #(.WIDTH(3), .ODD(1'b1)) u_dut_o3 (.clk(clk), .reset(reset), .bus(if3.slave));

  // ---------------- scoreboard ----------------
  // One expected-bit queue per DUT: entry = {is_parity, bit}.
  logic [1:0] exp_q[3][$];
  logic       par3_obs[$];
  int n_vec = 0;
  int n_err = 0;

  int acc_cyc = 0, fd_cyc = 0, dr_cyc = 0, fd_cnt = 0, stall_obs = 0;
  logic prev_dr = 1'b1;

  // ready-pattern control: 0 = always ready, 1 = random, 2 = stall plan
  int rmode = 0;
  int plan[16];
  int bit_idx = 0, stall_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a frame is the word's bits LSB first, then the parity bit,
  // which is 1 for odd parity when the count of ones is even.
  function automatic void push_frame(input int p, input logic [31:0] w, input int width, input bit odd);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < width; i++) begin
      exp_q[p].push_back({1'b0, w[i]});
      ones += int'(w[i]);
    end
    par = odd ? (ones % 2 == 0) : (ones % 2 == 1);
    exp_q[p].push_back({1'b1, par});
  endfunction

  task automatic mon(input int p, input string tag, input logic sv, input logic so, input logic sp,
                     input logic fd, input logic bz, input logic dr, input logic rdy);
    logic [1:0] h;
    logic       have;
    have = (exp_q[p].size() != 0);
    chk({tag, "_busy"},       32'(bz), 32'(have));
    chk({tag, "_din_ready"},  32'(dr), 32'(!have));
    chk({tag, "_sout_valid"}, 32'(sv), 32'(have));
    if (have) begin
      h = exp_q[p][0];
      chk({tag, "_sout"},       32'(so), 32'(h[0]));
      chk({tag, "_is_par"},     32'(sp), 32'(h[1]));
      chk({tag, "_frame_done"}, 32'(fd), 32'(h[1] & rdy));
      if (rdy) begin
        void'(exp_q[p].pop_front());
        if (p == 2 && h[1]) par3_obs.push_back(so);
      end
    end else begin
      chk({tag, "_idle_sout"},   32'(so), 32'd0);
      chk({tag, "_idle_is_par"}, 32'(sp), 32'd0);
      chk({tag, "_idle_fd"},     32'(fd), 32'd0);
    end
  endtask

  // ---------------- monitor: samples 2 ns after the falling edge ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        mon(0, "o8", if8o.sout_valid, if8o.sout, if8o.sout_is_par, if8o.frame_done,
            if8o.busy, if8o.din_ready, rdy8);
        mon(1, "e8", if8e.sout_valid, if8e.sout, if8e.sout_is_par, if8e.frame_done,
            if8e.busy, if8e.din_ready, rdy8);
        mon(2, "o3", if3.sout_valid, if3.sout, if3.sout_is_par, if3.frame_done,
            if3.busy, if3.din_ready, rdy3);
        if (if8o.frame_done) begin
          fd_cyc = cyc;
          fd_cnt++;
        end
        if (if8o.din_ready && !prev_dr) dr_cyc = cyc;
        if (if8o.sout_valid && !rdy8) stall_obs++;
      end
      prev_dr = if8o.din_ready;
    end
  end

  // ---------------- sout_ready driver ----------------
  initial begin
    forever begin
      @(negedge clk);
      case (rmode)
        0: rdy8 = 1'b1;
        1: rdy8 = ($urandom_range(0, 3) != 0);
        default: begin
          if (if8o.sout_valid && bit_idx < 16) begin
            if (stall_cnt < plan[bit_idx]) begin
              rdy8 = 1'b0;
              stall_cnt++;
            end else begin
              rdy8 = 1'b1;
              bit_idx++;
              stall_cnt = 0;
            end
          end else begin
            rdy8 = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- driver tasks (call at a falling edge) ----------------
  task automatic send8(input logic [7:0] w, input bit drop);
    int t;
    t = 0;
    din8 = w;
    dv8  = 1'b1;
    while (!if8o.din_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!if8o.din_ready) begin
      chk("accept8_timeout", 32'd0, 32'd1);
      dv8 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    push_frame(0, 32'(w), 8, 1'b1);
    push_frame(1, 32'(w), 8, 1'b0);
    if (drop) dv8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic send3(input logic [2:0] w);
    int t;
    t = 0;
    din3 = w;
    dv3  = 1'b1;
    while (!if3.din_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!if3.din_ready) begin
      chk("accept3_timeout", 32'd0, 32'd1);
      dv3 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    push_frame(2, 32'(w), 3, 1'b1);
    dv3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 400);
    chk("drain_in_time", 32'(t < 400), 32'd1);
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int         a1, fd0, st0;
    logic [7:0] w;
    logic [7:0] par_tbl;
    bit         drop;
    logic       exp_bit;

    for (int i = 0; i < 16; i++) plan[i] = 0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sout_valid", 32'(if8o.sout_valid), 32'd0);
    chk("rst_sout",       32'(if8o.sout), 32'd0);
    chk("rst_is_par",     32'(if8o.sout_is_par), 32'd0);
    chk("rst_busy",       32'(if8o.busy), 32'd0);
    chk("rst_frame_done", 32'(if8o.frame_done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_din_ready_o8", 32'(if8o.din_ready), 32'd1);
    chk("rst_din_ready_o3", 32'(if3.din_ready), 32'd1);

    // 1: 0xA5 with latency checks
    rmode = 0;
    send8(8'hA5, 1'b1);
    wait_done();
    chk("t1_frame_done_cycle", 32'(fd_cyc - acc_cyc), 32'd8);
    chk("t1_din_ready_cycle",  32'(dr_cyc - acc_cyc), 32'd9);

    // 2: 0x07 (odd and even DUTs), plus a din_valid pulse while busy
    send8(8'h07, 1'b1);
    @(negedge clk);
    din8 = 8'h33;
    dv8  = 1'b1;
    @(negedge clk);
    dv8  = 1'b0;
    wait_done();

    // 3: 0x3C with stalls at bit 2 (3 cycles) and parity (2 cycles)
    plan[2] = 3;
    plan[8] = 2;
    bit_idx = 0;
    stall_cnt = 0;
    fd0 = fd_cnt;
    st0 = stall_obs;
    rmode = 2;
    send8(8'h3C, 1'b1);
    wait_done();
    rmode = 0;
    chk("t3_frame_done_once", 32'(fd_cnt - fd0), 32'd1);
    chk("t3_stall_cycles",    32'(stall_obs - st0), 32'd5);

    // 4: din_valid held across two words
    send8(8'h01, 1'b0);
    a1 = acc_cyc;
    send8(8'hFF, 1'b1);
    chk("t4_accept_gap", 32'(acc_cyc - a1), 32'd10);
    wait_done();

    // 5: asynchronous reset mid-frame, then a clean frame
    send8(8'h5A, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    for (int p = 0; p < 3; p++) exp_q[p].delete();
    #1;
    chk("t5_sout_valid", 32'(if8o.sout_valid), 32'd0);
    chk("t5_sout",       32'(if8o.sout), 32'd0);
    chk("t5_is_par",     32'(if8o.sout_is_par), 32'd0);
    chk("t5_busy",       32'(if8o.busy), 32'd0);
    chk("t5_frame_done", 32'(if8o.frame_done), 32'd0);
    chk("t5_e8_busy",    32'(if8e.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send8(8'h80, 1'b1);
    wait_done();

    // 6: WIDTH = 3 sweep against the 3-input odd-parity table
    par3_obs.delete();
    for (int i = 0; i < 8; i++) begin
      send3(3'(i));
      wait_done();
    end
    par_tbl = 8'h69;  // parity for din = 0..7: 1,0,0,1,0,1,1,0
    chk("t6_parity_count", 32'(par3_obs.size()), 32'd8);
    for (int i = 0; i < 8 && i < par3_obs.size(); i++) begin
      exp_bit = par_tbl[i];
      chk($sformatf("t6_parity_%0d", i), 32'(par3_obs[i]), 32'(exp_bit));
    end

    // 7: random words with random consumer back-pressure
    rmode = 1;
    for (int i = 0; i < 40; i++) begin
      w    = 8'($urandom);
      drop = (i == 39) || ($urandom_range(0, 1) == 1);
      send8(w, drop);
      if (drop) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_done();
    rmode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
